// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: a registered scoreboard of in-flight writers with self-decrementing Tnew,
// youngest-writer shadowing, wildcard destinations and a multi-cycle mult/div busy counter.
module hazard_scoreboard #(
  parameter int NSLOT    = 2,
  parameter int RW       = 5,
  parameter int TW       = 3,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic [RW-1:0] D_rs,
  input  logic [RW-1:0] D_rt,
  input  logic          D_use_rs,
  input  logic          D_use_rt,
  input  logic [TW-1:0] D_tuse_rs,
  input  logic [TW-1:0] D_tuse_rt,
  input  logic [RW-1:0] D_wa,
  input  logic          D_wa_any,
  input  logic [TW-1:0] D_tnew,
  input  logic          D_md_start,
  input  logic          D_md_is_div,
  input  logic          D_md_use,
  output logic          stall,
  output logic          stall_rs,
  output logic          stall_rt,
  output logic          stall_md,
  output logic          md_busy
);

  logic [NSLOT-1:0] valid_q, valid_d;
  logic [NSLOT-1:0] any_q, any_d;
  logic [RW-1:0]    wa_q   [NSLOT];
  logic [RW-1:0]    wa_d   [NSLOT];
  logic [TW-1:0]    tnew_q [NSLOT];
  logic [TW-1:0]    tnew_d [NSLOT];
  logic [CW-1:0]    md_cnt_q, md_cnt_d;

  logic hit_rs, hit_rt, shadow_rs, shadow_rt;

  // Walk youngest to oldest; the first exact writer of a source hides every older slot.
  always_comb begin
    hit_rs    = 1'b0;
    hit_rt    = 1'b0;
    shadow_rs = 1'b0;
    shadow_rt = 1'b0;
    for (int k = 0; k < NSLOT; k++) begin
      if (!shadow_rs && valid_q[k] && (D_rs != '0) && (any_q[k] || (wa_q[k] == D_rs))
          && (tnew_q[k] > D_tuse_rs)) begin
        hit_rs = 1'b1;
      end
      if (!shadow_rt && valid_q[k] && (D_rt != '0) && (any_q[k] || (wa_q[k] == D_rt))
          && (tnew_q[k] > D_tuse_rt)) begin
        hit_rt = 1'b1;
      end
      if (valid_q[k] && !any_q[k] && (wa_q[k] == D_rs)) begin
        shadow_rs = 1'b1;
      end
      if (valid_q[k] && !any_q[k] && (wa_q[k] == D_rt)) begin
        shadow_rt = 1'b1;
      end
    end
  end

  assign stall_rs = D_use_rs & hit_rs;
  assign stall_rt = D_use_rt & hit_rt;
  assign md_busy  = (md_cnt_q != '0);
  assign stall_md = D_md_use & md_busy;
  assign stall    = stall_rs | stall_rt | stall_md;

  // Next scoreboard: slot 0 takes the D instruction or a bubble, older slots shift and age.
  always_comb begin
    valid_d = '0;
    any_d   = '0;
    for (int k = 0; k < NSLOT; k++) begin
      wa_d[k]   = '0;
      tnew_d[k] = '0;
    end
    if (!stall && !clr) begin
      valid_d[0] = (D_wa != '0) | D_wa_any;
      any_d[0]   = D_wa_any;
      wa_d[0]    = D_wa;
      tnew_d[0]  = D_tnew;
    end else begin
      valid_d[0] = 1'b0;
    end
    for (int k = 1; k < NSLOT; k++) begin
      valid_d[k] = valid_q[k-1] & ~clr;
      any_d[k]   = any_q[k-1];
      wa_d[k]    = wa_q[k-1];
      tnew_d[k]  = (tnew_q[k-1] != '0) ? (tnew_q[k-1] - TW'(1)) : '0;
    end

    if (D_md_start && !stall && !clr) begin
      md_cnt_d = D_md_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end else begin
      md_cnt_d = md_cnt_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q  <= '0;
      any_q    <= '0;
      md_cnt_q <= '0;
      for (int k = 0; k < NSLOT; k++) begin
        wa_q[k]   <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      any_q    <= any_d;
      wa_q     <= wa_d;
      tnew_q   <= tnew_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, hand sequences for md and
// flush/reset corners, then random stimulus against an age-based reference model.
module tb_hazard_scoreboard;

  localparam int NSLOT = 2;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT = 10;

  logic       clk = 1'b0;
  logic       reset, clr;
  logic [4:0] D_rs, D_rt, D_wa;
  logic       D_use_rs, D_use_rt, D_wa_any, D_md_start, D_md_is_div, D_md_use;
  logic [2:0] D_tuse_rs, D_tuse_rt, D_tnew;
  logic       stall, stall_rs, stall_rt, stall_md, md_busy;

  hazard_scoreboard #(.NSLOT(NSLOT), .RW(5), .TW(3), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CW(4)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .D_rs(D_rs), .D_rt(D_rt), .D_use_rs(D_use_rs), .D_use_rt(D_use_rt),
    .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_wa(D_wa), .D_wa_any(D_wa_any), .D_tnew(D_tnew),
    .D_md_start(D_md_start), .D_md_is_div(D_md_is_div), .D_md_use(D_md_use),
    .stall(stall), .stall_rs(stall_rs), .stall_rt(stall_rt), .stall_md(stall_md), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, clr;
    logic [4:0] rs, rt, wa;
    logic       use_rs, use_rt, any, mds, mdd, mdu;
    logic [2:0] tuse_rs, tuse_rt, tnew;
    logic       e_rs, e_rt, e_md, e_busy;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: each in-flight instruction remembered with its issue-time Tnew;
  // entry at age k has k cycles of countdown behind it.
  bit m_v [NSLOT];
  int m_wa [NSLOT];
  bit m_any [NSLOT];
  int m_tnew [NSLOT];
  int m_md = 0;

  function automatic vec_t mk(int rst_n, int clr_i, int rs, int use_rs, int tuse_rs,
                              int rt, int use_rt, int tuse_rt, int wa, int any, int tnew,
                              int mds, int mdd, int mdu, int e_rs, int e_rt, int e_md, int e_busy);
    vec_t v;
    v.rst_n = rst_n[0]; v.clr = clr_i[0];
    v.rs = rs[4:0]; v.use_rs = use_rs[0]; v.tuse_rs = tuse_rs[2:0];
    v.rt = rt[4:0]; v.use_rt = use_rt[0]; v.tuse_rt = tuse_rt[2:0];
    v.wa = wa[4:0]; v.any = any[0]; v.tnew = tnew[2:0];
    v.mds = mds[0]; v.mdd = mdd[0]; v.mdu = mdu[0];
    v.e_rs = e_rs[0]; v.e_rt = e_rt[0]; v.e_md = e_md[0]; v.e_busy = e_busy[0];
    return v;
  endfunction

  function automatic bit model_haz(int s, int tuse);
    int rem;
    if (s == 0) return 1'b0;
    for (int k = 0; k < NSLOT; k++) begin
      if (m_v[k] && (m_any[k] || m_wa[k] == s)) begin
        rem = (m_tnew[k] > k) ? m_tnew[k] - k : 0;
        if (rem > tuse) return 1'b1;
      end
      if (m_v[k] && !m_any[k] && m_wa[k] == s) return 1'b0;
    end
    return 1'b0;
  endfunction

  task automatic model_update(input vec_t v, input bit ms);
    if (!v.rst_n) begin
      for (int k = 0; k < NSLOT; k++) m_v[k] = 1'b0;
      m_md = 0;
    end else begin
      for (int k = NSLOT - 1; k >= 1; k--) begin
        m_v[k] = m_v[k-1] && !v.clr; m_wa[k] = m_wa[k-1];
        m_any[k] = m_any[k-1]; m_tnew[k] = m_tnew[k-1];
      end
      m_v[0] = !ms && !v.clr && (v.wa != 0 || v.any);
      m_wa[0] = int'(v.wa); m_any[0] = v.any; m_tnew[0] = int'(v.tnew);
      if (v.mds && !ms && !v.clr) m_md = v.mdd ? DIV_LAT : MULT_LAT;
      else if (m_md > 0) m_md = m_md - 1;
    end
  endtask

  task automatic check(input string tag, input string sig, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0b expected %0b at %0t", tag, sig, act, exp, $time);
    end
  endtask

  // Drive one D-cycle, compare outputs, clock it and advance the model.
  task automatic step(input vec_t v, input bit use_model, input string tag);
    bit m_rs, m_rt, m_mdst, m_busy, ms;
    reset = v.rst_n; clr = v.clr;
    D_rs = v.rs; D_use_rs = v.use_rs; D_tuse_rs = v.tuse_rs;
    D_rt = v.rt; D_use_rt = v.use_rt; D_tuse_rt = v.tuse_rt;
    D_wa = v.wa; D_wa_any = v.any; D_tnew = v.tnew;
    D_md_start = v.mds; D_md_is_div = v.mdd; D_md_use = v.mdu;
    #2;
    m_rs = v.use_rs && model_haz(int'(v.rs), int'(v.tuse_rs));
    m_rt = v.use_rt && model_haz(int'(v.rt), int'(v.tuse_rt));
    m_busy = (m_md != 0);
    m_mdst = v.mdu && m_busy;
    ms = m_rs | m_rt | m_mdst;
    if (use_model) begin
      check(tag, "stall_rs", stall_rs, m_rs);
      check(tag, "stall_rt", stall_rt, m_rt);
      check(tag, "stall_md", stall_md, m_mdst);
      check(tag, "md_busy", md_busy, m_busy);
      check(tag, "stall", stall, ms);
    end else begin
      check(tag, "stall_rs", stall_rs, v.e_rs);
      check(tag, "stall_rt", stall_rt, v.e_rt);
      check(tag, "stall_md", stall_md, v.e_md);
      check(tag, "md_busy", md_busy, v.e_busy);
      check(tag, "stall", stall, v.e_rs | v.e_rt | v.e_md);
    end
    @(posedge clk);
    model_update(v, ms);
    #1;
  endtask

  vec_t tbl[$];
  vec_t nop, r;

  initial begin
    for (int k = 0; k < NSLOT; k++) begin
      m_v[k] = 1'b0; m_wa[k] = 0; m_any[k] = 1'b0; m_tnew[k] = 0;
    end
    nop = mk(1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0);
    reset = 1'b0; clr = 1'b0;
    D_rs = '0; D_rt = '0; D_wa = '0; D_use_rs = 1'b0; D_use_rt = 1'b0; D_wa_any = 1'b0;
    D_tuse_rs = '0; D_tuse_rt = '0; D_tnew = '0;
    D_md_start = 1'b0; D_md_is_div = 1'b0; D_md_use = 1'b0;
    @(posedge clk); #1;
    r = nop; r.rst_n = 1'b0;
    // Two unchecked reset cycles bring the DUT out of its unknown power-up state.
    reset = 1'b0; @(posedge clk); model_update(r, 1'b0); #1;
    @(posedge clk); model_update(r, 1'b0); #1;

    //        rst clr rs ur tr  rt ut tt  wa any tn mds mdd mdu  ers ert emd ebz
    tbl.push_back(mk(1,0, 0,0,0, 0,0,0,  0,0,0, 0,0,0, 0,0,0,0));   // reset state
    tbl.push_back(mk(1,0, 0,0,0, 0,0,0,  5,0,2, 0,0,0, 0,0,0,0));   // lw $5
    tbl.push_back(mk(1,0, 5,1,1, 0,0,0,  6,0,1, 0,0,0, 1,0,0,0));   // add uses $5: stall
    tbl.push_back(mk(1,0, 5,1,1, 0,0,0,  6,0,1, 0,0,0, 0,0,0,0));   // lw tnew now 1: go
    tbl.push_back(mk(1,0, 0,0,0, 0,0,0,  0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0, 0,0,0, 0,0,0,  5,0,2, 0,0,0, 0,0,0,0));   // lw $5
    tbl.push_back(mk(1,0, 0,0,0, 0,0,0,  5,0,1, 0,0,0, 0,0,0,0));   // addu $5
    tbl.push_back(mk(1,0, 5,1,0, 0,0,0,  0,0,0, 0,0,0, 1,0,0,0));   // beq: addu in E
    tbl.push_back(mk(1,0, 5,1,0, 0,0,0,  0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0, 0,0,0, 0,0,0,  5,0,3, 0,0,0, 0,0,0,0));   // lw $5 tnew 3
    tbl.push_back(mk(1,0, 0,0,0, 0,0,0,  5,0,0, 0,0,0, 0,0,0,0));   // addu $5 tnew 0
    tbl.push_back(mk(1,0, 5,1,1, 5,1,1,  0,0,0, 0,0,0, 0,0,0,0));   // lw fully shadowed
    tbl.push_back(mk(1,0, 0,0,0, 0,0,0,  0,1,2, 0,0,0, 0,0,0,0));   // wildcard tnew 2
    tbl.push_back(mk(1,0, 0,0,0, 0,1,0,  0,1,3, 0,0,0, 0,0,0,0));   // rt=0 never matches
    tbl.push_back(mk(1,0, 0,1,0, 17,1,1, 0,0,0, 0,0,0, 0,1,0,0));   // wildcard hits rt
    tbl.push_back(mk(1,0, 0,0,0, 17,1,1, 0,0,0, 0,0,0, 0,1,0,0));   // older wildcard still
    tbl.push_back(mk(1,0, 0,0,0, 17,1,1, 0,0,0, 0,0,0, 0,0,0,0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // div then mflo: busy exactly DIV_LAT cycles, mflo issues the cycle after.
    step(mk(1,0, 0,0,0, 0,0,0, 0,0,0, 1,1,1, 0,0,0,0), 1'b0, "div_issue");
    for (int i = 0; i < DIV_LAT; i++)
      step(mk(1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,1, 0,0,1,1), 1'b0, $sformatf("mflo_wait%0d", i));
    step(mk(1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,1, 0,0,0,0), 1'b0, "mflo_go");
    step(mk(1,0, 0,0,0, 0,0,0, 0,0,0, 1,0,1, 0,0,0,0), 1'b0, "mult_issue");
    for (int i = 0; i < MULT_LAT; i++)
      step(mk(1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,1), 1'b0, $sformatf("mult_busy%0d", i));
    step(nop, 1'b0, "mult_done");

    // Flush empties slots but leaves md counting; reset then clears md.
    step(mk(1,0, 0,0,0, 0,0,0, 5,0,2, 1,0,1, 0,0,0,0), 1'b0, "fl_lw_mult");
    step(mk(1,1, 0,0,0, 0,0,0, 7,0,3, 0,0,0, 0,0,0,1), 1'b0, "fl_clr");
    step(mk(1,0, 5,1,0, 7,1,0, 0,0,0, 0,0,0, 0,0,0,1), 1'b0, "fl_empty");
    step(mk(0,1, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,1), 1'b0, "rst_clr");
    step(nop, 1'b0, "rst_md_zero");
    step(mk(1,0, 0,0,0, 0,0,0, 5,0,3, 0,0,0, 0,0,0,0), 1'b0, "rst_lw");
    step(mk(0,0, 5,1,0, 0,0,0, 0,0,0, 0,0,0, 1,0,0,0), 1'b0, "rst_edge");
    step(mk(0,0, 5,1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0), 1'b0, "rst_hold");
    step(mk(1,0, 5,1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0), 1'b0, "rst_after");

    for (int i = 0; i < 1500; i++) begin
      r.rst_n = ($urandom_range(63) != 0);
      r.clr = ($urandom_range(31) == 0);
      r.rs = 5'($urandom_range(7)); r.rt = 5'($urandom_range(7)); r.wa = 5'($urandom_range(7));
      r.use_rs = 1'($urandom); r.use_rt = 1'($urandom);
      r.tuse_rs = 3'($urandom_range(3)); r.tuse_rt = 3'($urandom_range(3));
      r.any = ($urandom_range(7) == 0);
      r.tnew = 3'($urandom_range(4));
      r.mds = ($urandom_range(15) == 0);
      r.mdd = 1'($urandom);
      r.mdu = r.mds | ($urandom_range(3) == 0);
      r.e_rs = 1'b0; r.e_rt = 1'b0; r.e_md = 1'b0; r.e_busy = 1'b0;
      step(r, 1'b1, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the fixed E/M stall unit of the 5-stage MIPS pipeline. It holds a registered scoreboard of NSLOT in-flight writers (slot 0 = E, slot 1 = M, and so on). Each slot's Tnew counts down in hardware. D-stage Tuse is compared against the youngest relevant writer only, which removes spurious stalls. The block adds late-known-destination writers (wildcard) and a multi-cycle mult/div busy counter. It sits beside the D stage and drives the D/E enable and the E bubble insert.

Parameters:
NSLOT, 2, number of tracked stages after D (slot 0 = E)
RW, 5, register-address width
TW, 3, Tuse/Tnew width
MULT_LAT, 5, mult/multu busy cycles
DIV_LAT, 10, div/divu busy cycles (must be >= MULT_LAT and < 2^CW)
CW, 4, md counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
clr  in  1  synchronous flush of all scoreboard slots
D_rs  in  RW  D source rs
D_rt  in  RW  D source rt
D_use_rs  in  1  D reads rs
D_use_rt  in  1  D reads rt
D_tuse_rs  in  TW  cycles until rs is needed
D_tuse_rt  in  TW  cycles until rt is needed
D_wa  in  RW  D destination (0 = none)
D_wa_any  in  1  destination unknown until later (may write any nonzero reg)
D_tnew  in  TW  Tnew of the D instr once it is in E
D_md_start  in  1  D is mult/multu/div/divu
D_md_is_div  in  1  selects DIV_LAT
D_md_use  in  1  D touches HI/LO or the md unit
stall  out  1  stall_rs | stall_rt | stall_md
stall_rs  out  1  rs hazard
stall_rt  out  1  rt hazard
stall_md  out  1  md-unit hazard
md_busy  out  1  md counter nonzero

Behaviour:
- Slot k state: valid, wa[RW], any, tnew[TW].
- reset==0 at a clock edge: all slots invalid with tnew=0, md_cnt=0. All outputs are therefore 0 from the next cycle. Reset has priority over clr and any issue, including mid-countdown.
- Each edge (reset==1):
  - For k>=1: slot[k] <= slot[k-1], with tnew decremented and saturating at 0. Slot NSLOT-1 is discarded.
  - slot[0] <= bubble (invalid) if stall or clr.
  - Otherwise slot[0] <= {valid = (D_wa!=0)|D_wa_any, D_wa, D_wa_any, D_tnew}.
  - clr==1: every slot becomes invalid. md_cnt is unaffected.
- Later stages never freeze; only D stalls.
- Match for source s (rs or rt) at slot k: valid_k & s!=0 & (wa_k==s | any_k).
- Hazard at slot k: match_k & tnew_k > tuse_s & no slot j<k with valid_j & !any_j & wa_j==s.
  - An exact younger writer shadows all older writers, because forwarding supplies the youngest value.
  - Wildcard entries never shadow.
- stall_rs = D_use_rs & OR over k of hazard_k(rs). stall_rt uses the same rule for rt.
- md counter:
  - If D_md_start & !stall & !clr: md_cnt <= (D_md_is_div ? DIV_LAT : MULT_LAT).
  - Else if md_cnt!=0: md_cnt <= md_cnt-1.
  - md_busy = (md_cnt!=0). It goes high the cycle the md instr is in E and stays high for exactly LAT cycles.
  - stall_md = D_md_use & md_busy.
- All outputs are combinational from registered state and D inputs. No combinational loop exists: stall feeds only next-state.
- D_tnew=0 writers are entered (forwardable, never stall). tnew already 0 stays 0.
- A new md start while busy cannot occur, because stall_md blocks it (D_md_use must be set for start instructions).
- Width: comparisons are unsigned TW-bit.

Test Plan:
- Reset: hold reset=0 for 2 cycles with D_use_rs=1, D_rs=5 after an issued lw $5 → all slots clear, stall=0, md_busy=0.
- Load-use:
  - Issue lw $5 (D_wa=5, D_tnew=2). Next cycle D = add using rs=5, tuse=1 → stall_rs=1 for exactly 1 cycle.
  - The cycle after, stall=0 (slot1 tnew=1 <= 1).
- Shadowing: issue lw $5 (tnew 2), then addu $5 (tnew 1, wa 5). Next D is beq rs=5 (tuse 0).
  - Stall 1 cycle due to the addu in E.
  - Afterwards stall=0 even though lw earlier occupied a slot (fully shadowed).
- Wildcard: issue entry D_wa_any=1, D_tnew=2; next D uses rt=17, tuse=1 → stall_rt=1. With D_rt=0 → stall_rt=0.
- md:
  - Issue div (DIV_LAT=10) → md_busy high for exactly 10 cycles.
  - mflo in D during that window → stall_md=1; mflo issues on cycle 11.
  - mult → 5 busy cycles.
- Flush/priority:
  - clr=1 with lw $5 pending and D issuing → all slots empty next cycle, D not entered, md_cnt keeps counting.
  - reset=0 with clr=1 → md_cnt=0.
